// File: rtl/famicom_pad_port.sv
// famicom_pad_port: two 4021-style pad shift registers behind $4016/$4017.
// Optional turbo on A/B via `define PAD_TURBO_EN.
module famicom_pad_port #(
  parameter int          SYNC_STAGES = 2,
  parameter logic        FILL        = 1'b0,
  parameter logic [15:0] TURBO_DIV   = 16'd29830
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       OUT_0,
  input  logic       P4016_CUP,
  input  logic       P4017_CUP,
  input  logic [7:0] BTN1,
  input  logic [7:0] BTN2,
  input  logic [1:0] TURBO1,
  input  logic [1:0] TURBO2,
  output logic       P4016_D0,
  output logic       P4017_D0,
  output logic [3:0] SHIFT_CNT1,
  output logic [3:0] SHIFT_CNT2
);

  // bit 2 = OUT_0, bit 1 = P4017_CUP, bit 0 = P4016_CUP
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [2:0]                  sync_out;
  logic [1:0]                  cup_hist;
  logic                        load;
  logic                        edge1;
  logic                        edge2;
  logic [7:0]                  eff1;
  logic [7:0]                  eff2;
  logic [7:0]                  sr1;
  logic [7:0]                  sr2;
  logic [3:0]                  cnt1;
  logic [3:0]                  cnt2;

  // Synchronizer chain for the strobe and both read strobes
  always_ff @(posedge CLK) begin
    if (RES) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= {OUT_0, P4017_CUP, P4016_CUP};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // History of the synchronized CUP lines for rising-edge detection
  always_ff @(posedge CLK) begin
    if (RES) begin
      cup_hist <= 2'b00;
    end else begin
      cup_hist <= sync_out[1:0];
    end
  end

  // The synchronized OUT_0 sample is the same age as the "current"
  // CUP sample in the edge detector, so both decisions line up.
  assign load  = sync_out[2];
  assign edge1 = sync_out[0] & ~cup_hist[0];
  assign edge2 = sync_out[1] & ~cup_hist[1];

`ifdef PAD_TURBO_EN
  logic [15:0] turbo_cnt;
  logic        turbo_phase;

  // Free-running turbo divider; phase flips on every wrap
  always_ff @(posedge CLK) begin
    if (RES) begin
      turbo_cnt   <= 16'd0;
      turbo_phase <= 1'b0;
    end else if (turbo_cnt == TURBO_DIV - 16'd1) begin
      turbo_cnt   <= 16'd0;
      turbo_phase <= ~turbo_phase;
    end else begin
      turbo_cnt <= turbo_cnt + 16'd1;
    end
  end

  assign eff1 = {BTN1[7:2], BTN1[1:0] | (TURBO1 & {2{turbo_phase}})};
  assign eff2 = {BTN2[7:2], BTN2[1:0] | (TURBO2 & {2{turbo_phase}})};
`else
  logic unused_turbo;

  assign unused_turbo = ^{TURBO1, TURBO2, TURBO_DIV};
  assign eff1         = BTN1;
  assign eff2         = BTN2;
`endif

  // Pad 1 register: load has priority over a shift
  always_ff @(posedge CLK) begin
    if (RES) begin
      sr1  <= 8'hFF;
      cnt1 <= 4'd0;
    end else if (load) begin
      sr1  <= ~eff1;
      cnt1 <= 4'd0;
    end else if (edge1) begin
      sr1  <= {FILL, sr1[7:1]};
      cnt1 <= (cnt1 == 4'd8) ? 4'd8 : cnt1 + 4'd1;
    end
  end

  // Pad 2 register: same behaviour, own read strobe
  always_ff @(posedge CLK) begin
    if (RES) begin
      sr2  <= 8'hFF;
      cnt2 <= 4'd0;
    end else if (load) begin
      sr2  <= ~eff2;
      cnt2 <= 4'd0;
    end else if (edge2) begin
      sr2  <= {FILL, sr2[7:1]};
      cnt2 <= (cnt2 == 4'd8) ? 4'd8 : cnt2 + 4'd1;
    end
  end

  assign P4016_D0   = sr1[0];
  assign P4017_D0   = sr2[0];
  assign SHIFT_CNT1 = cnt1;
  assign SHIFT_CNT2 = cnt2;

endmodule
